// File: rtl/present_rnd_pkg.sv
// Shared constants, FSM encoding and LFSR feedback helper for the masked
// PRESENT randomness source.
package present_rnd_pkg;

  localparam int LFSR_W = 128;

  // Feedback taps of x^128 + x^7 + x^2 + x + 1 (Fibonacci form).
  localparam int TAP_A = 127;
  localparam int TAP_B = 6;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] ZERO_SEED_REPL = 128'h1;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } rnd_state_e;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/msk_lfsr_adv.sv
// Combinational advance of the 128-bit LFSR by STEPS single-bit steps;
// o_bits[0] is the first feedback bit produced.
module msk_lfsr_adv
  import present_rnd_pkg::*;
#(
  parameter int STEPS = 64
) (
  input  logic [LFSR_W-1:0] i_state,
  output logic [LFSR_W-1:0] o_state,
  output logic [STEPS-1:0]  o_bits
);

  // Unrolled shift chain
  always_comb begin
    logic [LFSR_W-1:0] v_s;
    logic              v_fb;
    v_s    = i_state;
    o_bits = '0;
    for (int k = 0; k < STEPS; k++) begin
      v_fb      = lfsr_feedback(v_s);
      o_bits[k] = v_fb;
      v_s       = {v_s[LFSR_W-2:0], v_fb};
    end
    o_state = v_s;
  end

endmodule

// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for the masked PRESENT S-box layer: seeded LFSR
// with warm-up after every seed load and a periodic reseed request.
module msk_rnd_source
  import present_rnd_pkg::*;
#(
  parameter int RND_W         = 32,
  parameter int WARM          = 128,
  parameter int RESEED_PERIOD = 65536
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [127:0]      seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              rnd_en,
  output logic [RND_W-1:0]  rnd1,
  output logic [RND_W-1:0]  rnd2,
  output logic              rnd_valid,
  output logic              reseed_req,
  output logic              zero_seed
);

  localparam int WC_W = (WARM > 1) ? $clog2(WARM) : 1;
  localparam int OC_W = $clog2(RESEED_PERIOD + 1);

  rnd_state_e          r_state;
  rnd_state_e          w_state_nxt;
  logic                r_rst_done;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [WC_W-1:0]     r_warm_cnt;
  logic [OC_W-1:0]     r_out_cnt;
  logic [OC_W-1:0]     w_out_cnt_inc;
  logic [RND_W-1:0]    r_rnd1;
  logic [RND_W-1:0]    r_rnd2;
  logic                r_rnd_valid;
  logic                r_reseed_req;
  logic                r_zero_seed;
  logic                w_seed_ready;
  logic                w_seed_acc;
  logic                w_seed_zero;
  logic [LFSR_W-1:0]   w_adv_state;
  logic [2*RND_W-1:0]  w_adv_bits;

  msk_lfsr_adv #(
    .STEPS (2 * RND_W)
  ) u_adv (
    .i_state (r_lfsr),
    .o_state (w_adv_state),
    .o_bits  (w_adv_bits)
  );

  assign w_seed_acc    = seed_valid && w_seed_ready;
  assign w_seed_zero   = (seed_in == 128'd0);
  assign w_out_cnt_inc = (r_out_cnt == OC_W'(RESEED_PERIOD)) ? r_out_cnt
                                                             : r_out_cnt + OC_W'(1);

  // State register; r_rst_done keeps seed_ready low until the first edge after reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= ST_UNSEEDED;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_UNSEEDED: begin
        if (w_seed_acc) w_state_nxt = ST_WARMUP;
        else            w_state_nxt = ST_UNSEEDED;
      end
      ST_WARMUP: begin
        if (r_warm_cnt == WC_W'(WARM - 1)) w_state_nxt = ST_RUN;
        else                               w_state_nxt = ST_WARMUP;
      end
      ST_RUN: begin
        if (w_seed_acc) w_state_nxt = ST_WARMUP;
        else            w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_UNSEEDED;
    endcase
  end

  // Output decode: seed_ready depends on state only
  always_comb begin
    w_seed_ready = 1'b0;
    if (!r_rst_done) begin
      w_seed_ready = 1'b0;
    end else begin
      case (r_state)
        ST_UNSEEDED: w_seed_ready = 1'b1;
        ST_RUN:      w_seed_ready = 1'b1;
        default:     w_seed_ready = 1'b0;
      endcase
    end
  end

  // Datapath: seed load, warm-up advance, word delivery and reseed tracking
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lfsr       <= '0;
      r_warm_cnt   <= '0;
      r_out_cnt    <= '0;
      r_rnd1       <= '0;
      r_rnd2       <= '0;
      r_rnd_valid  <= 1'b0;
      r_reseed_req <= 1'b0;
      r_zero_seed  <= 1'b0;
    end else begin
      r_zero_seed <= w_seed_acc && w_seed_zero;
      if (w_seed_acc) begin
        r_lfsr       <= w_seed_zero ? ZERO_SEED_REPL : seed_in;
        r_warm_cnt   <= '0;
        r_out_cnt    <= '0;
        r_reseed_req <= 1'b0;
        r_rnd_valid  <= 1'b0;
      end else begin
        case (r_state)
          ST_WARMUP: begin
            r_lfsr      <= w_adv_state;
            r_warm_cnt  <= r_warm_cnt + WC_W'(1);
            r_rnd_valid <= 1'b0;
          end
          ST_RUN: begin
            if (rnd_en) begin
              r_lfsr      <= w_adv_state;
              r_rnd1      <= w_adv_bits[RND_W-1:0];
              r_rnd2      <= w_adv_bits[2*RND_W-1:RND_W];
              r_rnd_valid <= 1'b1;
              r_out_cnt   <= w_out_cnt_inc;
              if (w_out_cnt_inc == OC_W'(RESEED_PERIOD)) r_reseed_req <= 1'b1;
            end else begin
              r_rnd_valid <= 1'b0;
            end
          end
          default: r_rnd_valid <= 1'b0;
        endcase
      end
    end
  end

  assign seed_ready = w_seed_ready;
  assign rnd1       = r_rnd1;
  assign rnd2       = r_rnd2;
  assign rnd_valid  = r_rnd_valid;
  assign reseed_req = r_reseed_req;
  assign zero_seed  = r_zero_seed;

endmodule

// File: tb/tb_msk_rnd_source.sv
// Randomized self-checking bench for msk_rnd_source against a cycle-level
// behavioural model of the randomness source.
module tb_msk_rnd_source;

  localparam int RND_W = 32;
  localparam int WARM  = 4;
  localparam int PER   = 3;

  logic              clk = 1'b0;
  logic              nrst;
  logic [127:0]      seed_in;
  logic              seed_valid;
  logic              seed_ready;
  logic              rnd_en;
  logic [RND_W-1:0]  rnd1;
  logic [RND_W-1:0]  rnd2;
  logic              rnd_valid;
  logic              reseed_req;
  logic              zero_seed;

  always #5 clk = ~clk;

  msk_rnd_source #(
    .RND_W         (RND_W),
    .WARM          (WARM),
    .RESEED_PERIOD (PER)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd_en     (rnd_en),
    .rnd1       (rnd1),
    .rnd2       (rnd2),
    .rnd_valid  (rnd_valid),
    .reseed_req (reseed_req),
    .zero_seed  (zero_seed)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: 0 = unseeded, 1 = warming up, 2 = running
  int               m_st;
  bit               m_rdone;
  logic [127:0]     m_lfsr;
  int               m_warm;
  int               m_out;
  logic [RND_W-1:0] m_r1;
  logic [RND_W-1:0] m_r2;
  bit               m_valid;
  bit               m_req;
  bit               m_zero;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] lfsr_steps(input logic [127:0] s, input int n,
                                              output logic [63:0] bits);
    logic b;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      b       = s[127] ^ s[6] ^ s[1] ^ s[0];
      bits[i] = b;
      s       = {s[126:0], b};
    end
    return s;
  endfunction

  task automatic model_reset();
    m_st = 0; m_rdone = 1'b0; m_lfsr = '0; m_warm = 0; m_out = 0;
    m_r1 = '0; m_r2 = '0; m_valid = 1'b0; m_req = 1'b0; m_zero = 1'b0;
  endtask

  task automatic model_cycle(input logic en, input logic sv, input logic [127:0] sd);
    bit          ready;
    bit          acc;
    logic [63:0] bits;
    ready  = m_rdone && (m_st != 1);
    acc    = sv && ready;
    m_zero = acc && (sd == 128'd0);
    if (acc) begin
      m_lfsr  = (sd == 128'd0) ? 128'h1 : sd;
      m_warm  = 0;
      m_out   = 0;
      m_req   = 1'b0;
      m_valid = 1'b0;
      m_st    = 1;
    end else if (m_st == 1) begin
      m_lfsr  = lfsr_steps(m_lfsr, 2 * RND_W, bits);
      m_warm  = m_warm + 1;
      m_valid = 1'b0;
      if (m_warm == WARM) m_st = 2;
    end else if (m_st == 2 && en) begin
      m_lfsr  = lfsr_steps(m_lfsr, 2 * RND_W, bits);
      m_r1    = bits[RND_W-1:0];
      m_r2    = bits[2*RND_W-1:RND_W];
      m_valid = 1'b1;
      m_out   = m_out + 1;
      if (m_out >= PER) m_req = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    m_rdone = 1'b1;
  endtask

  task automatic cyc(input logic en, input logic sv, input logic [127:0] sd);
    rnd_en = en; seed_valid = sv; seed_in = sd;
    @(posedge clk);
    if (!nrst) model_reset();
    else       model_cycle(en, sv, sd);
    #1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("seed_ready", seed_ready, m_rdone && (m_st != 1));
      check("rnd_valid",  rnd_valid,  m_valid);
      check("reseed_req", reseed_req, m_req);
      check("zero_seed",  zero_seed,  m_zero);
      check("rnd1",       rnd1,       m_r1);
      check("rnd2",       rnd2,       m_r2);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pin_s;
    logic [63:0]  pin_b;
    int           n;
    int           pulses;
    logic         sv;
    logic [127:0] sd;

    // Hand-computed pins for the model's LFSR: seed 1, seven steps
    pin_s = lfsr_steps(128'h1, 7, pin_b);
    check("pin_state", pin_s, 128'hDA);
    check("pin_bits", pin_b[6:0], 7'h2D);

    nrst = 1'b1; rnd_en = 1'b0; seed_valid = 1'b0; seed_in = '0;
    #1 nrst = 1'b0;
    #1;
    model_reset();
    check("rst_seed_ready", seed_ready, 1'b0);
    check("rst_rnd_valid", rnd_valid, 1'b0);
    check("rst_rnd1", rnd1, 0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, '0);
    cyc(1'b1, 1'b1, 128'h5);
    nrst = 1'b1;
    cyc(1'b0, 1'b0, '0);

    // Seed and measure the warm-up window
    cyc(1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    n = 0;
    while (!seed_ready && n < 20) begin
      n++;
      cyc(1'b1, 1'b0, '0);
    end
    check("warm_cycles", n, WARM);

    // Enable pattern 1,0,1,1
    cyc(1'b1, 1'b0, '0);
    check("pat_v0", rnd_valid, 1'b1);
    cyc(1'b0, 1'b0, '0);
    check("pat_v1", rnd_valid, 1'b0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    check("pat_req", reseed_req, 1'b1);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    check("req_continue_v", rnd_valid, 1'b1);

    // Zero seed replaced by 1
    cyc(1'b0, 1'b1, 128'h0);
    check("zs_req_clr", reseed_req, 1'b0);
    pulses = (zero_seed == 1'b1) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (zero_seed) pulses++;
    end
    check("zs_pulses", pulses, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0);

    // Seed and rnd_en in the same RUN cycle: seed wins
    cyc(1'b1, 1'b1, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
    check("collide_valid", rnd_valid, 1'b0);
    check("collide_ready", seed_ready, 1'b0);
    cyc(1'b1, 1'b0, '0);

    // Asynchronous reset in the middle of warm-up
    #2 nrst = 1'b0;
    #1;
    check("arst_valid", rnd_valid, 1'b0);
    check("arst_rnd2", rnd2, 0);
    check("arst_ready", seed_ready, 1'b0);
    model_reset();
    cyc(1'b1, 1'b0, '0);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, '0);
    check("post_rst_valid", rnd_valid, 1'b0);

    // Randomized traffic with occasional (sometimes zero) reseeds
    for (int i = 0; i < 600; i++) begin
      sv = ($urandom_range(0, 24) == 0) || (m_st == 0 && $urandom_range(0, 3) == 0);
      sd = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) sd = '0;
      cyc(1'($urandom_range(0, 1)), sv, sd);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
